iir_mac_sched: RTL

//  Sequencer for a time-multiplexed direct-form-I IIR section: one shared MAC serves

---
 rtl/iir_mac_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/iir_mac_sched.sv
// iir_mac_sched: tap sequencer for a time-multiplexed direct-form-I IIR section
//  One shared MAC serves the zero and pole taps. Per accepted sample: write x into
//  the x ring, step the zero taps, step the pole taps, wait out the MAC latency,
//  then write y into the y ring. Carries no sample data, only addresses/strobes.
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  en                  1 = accept new samples; 0 = finish current sequence, then hold
//  in_valid/in_ready   sample handshake; accept = in_valid & in_ready at the edge
//  clr_ovr/overrun     clear / sticky flag for samples offered while not ready
//  x_wr_en/x_wr_addr   x ring write strobe and index
//  rd_addr/sel_y       ring read index for the current tap and ring select (1 = y)
//  coef_addr           coefficient index for the current tap
//  mac_clr/mac_en      MAC load-instead-of-accumulate / MAC step strobes
//  y_wr_en/y_wr_addr   y ring write strobe and index
//  out_valid           one-cycle pulse when y is valid
module iir_mac_sched #(
    parameter int N_ZERO  = 4,
    parameter int N_POLE  = 3,
    parameter int AW      = 3,
    parameter int CAW     = 3,
    parameter int MAC_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           clr_ovr,
    output logic           overrun,
    output logic           x_wr_en,
    output logic [AW-1:0]  x_wr_addr,
    output logic [AW-1:0]  rd_addr,
    output logic           sel_y,
    output logic [CAW-1:0] coef_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           y_wr_en,
    output logic [AW-1:0]  y_wr_addr,
    output logic           out_valid
);
    typedef enum logic [2:0] {IDLE, WRX, ZERO, POLE, DRAIN, DONE} state_t;
    localparam int MX = (N_ZERO > N_POLE) ? ((N_ZERO > MAC_LAT) ? N_ZERO : MAC_LAT)
                                          : ((N_POLE > MAC_LAT) ? N_POLE : MAC_LAT);
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] Z_LAST = CW'(N_ZERO - 1);
    localparam logic [CW-1:0] P_LAST = CW'((N_POLE > 0) ? N_POLE - 1 : 0);
    localparam logic [CW-1:0] D_LAST = CW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    // Empty phases are skipped at elaboration time.
    localparam state_t AFTER_Z = (N_POLE > 0) ? POLE : (MAC_LAT > 0) ? DRAIN : DONE;
    localparam state_t AFTER_P = (MAC_LAT > 0) ? DRAIN : DONE;

    state_t        state, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] xp, yp;

    always_comb begin
        st_n  = state;
        cnt_n = '0;
        case (state)
            IDLE:  st_n = (in_valid && in_ready) ? WRX : IDLE;
            WRX:   st_n = ZERO;
            ZERO: begin
                st_n  = (cnt == Z_LAST) ? AFTER_Z : ZERO;
                cnt_n = (cnt == Z_LAST) ? '0 : cnt + CW'(1);
            end
            POLE: begin
                st_n  = (cnt == P_LAST) ? AFTER_P : POLE;
                cnt_n = (cnt == P_LAST) ? '0 : cnt + CW'(1);
            end
            DRAIN: begin
                st_n  = (cnt == D_LAST) ? DONE : DRAIN;
                cnt_n = (cnt == D_LAST) ? '0 : cnt + CW'(1);
            end
            DONE:    st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state
    // they describe; tap k (or j-1) is cnt_n in the ZERO (POLE) phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            xp        <= '0;
            yp        <= '0;
            in_ready  <= 1'b0;
            overrun   <= 1'b0;
            x_wr_en   <= 1'b0;
            x_wr_addr <= '0;
            rd_addr   <= '0;
            sel_y     <= 1'b0;
            coef_addr <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            y_wr_en   <= 1'b0;
            y_wr_addr <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= st_n;
            cnt       <= cnt_n;
            in_ready  <= (st_n == IDLE) && en;
            overrun   <= (in_valid && !in_ready) || (overrun && !clr_ovr);
            x_wr_en   <= st_n == WRX;
            mac_en    <= (st_n == ZERO) || (st_n == POLE);
            mac_clr   <= (st_n == ZERO) && (cnt_n == '0);
            y_wr_en   <= st_n == DONE;
            out_valid <= st_n == DONE;
            if (st_n == WRX)
                x_wr_addr <= xp;
            if (st_n == DONE)
                y_wr_addr <= yp;
            if (st_n == ZERO) begin
                sel_y     <= 1'b0;
                coef_addr <= CAW'(cnt_n);
                rd_addr   <= xp - AW'(cnt_n);
            end
            // yp - (cnt_n + 1) written as yp + ~cnt_n
            if (st_n == POLE) begin
                sel_y     <= 1'b1;
                coef_addr <= CAW'(N_ZERO) + CAW'(cnt_n);
                rd_addr   <= yp + ~AW'(cnt_n);
            end
            if (state == DONE) begin
                xp <= xp + AW'(1);
                yp <= yp + AW'(1);
            end
        end
    end
endmodule
